// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                neg_q, neg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Request decode
  logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;

  assign is_div   = funct3[2];
  assign sgn1     = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                    (funct3 == 3'b110);
  assign sgn2     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg1     = sgn1 & op1[XLEN-1];
  assign neg2     = sgn2 & op2[XLEN-1];
  assign mag1     = neg1 ? -op1 : op1;
  assign mag2     = neg2 ? -op2 : op2;
  assign div_zero = is_div && (op2 == '0);
  assign div_ovf  = is_div && !funct3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? op1 : '1;
    else          special_res = funct3[1] ? '0 : op1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  // Truncated product of sign-extended operands covers signed and unsigned forms alike
  assign fast_prod = {{XLEN{neg1}}, op1} * {{XLEN{sgn2 & op2[XLEN-1]}}, op2};
  assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // One radix-2 step; prod_q holds {acc, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_hi;
  logic              qbit;
  logic [2*XLEN-1:0] step, signed_prod;
  logic [XLEN-1:0]   calc_res;

  assign mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign div_hi      = prod_q[2*XLEN-1:XLEN-1];
  assign qbit        = div_hi >= {1'b0, opnd_q};
  assign step        = funct3_q[2] ?
                       {(qbit ? div_hi[XLEN-1:0] - opnd_q : div_hi[XLEN-1:0]),
                        prod_q[XLEN-2:0], qbit} :
                       {mul_sum, prod_q[XLEN-1:1]};
  assign signed_prod = neg_q ? -step : step;

  always_comb begin
    calc_res = '0;
    if (!funct3_q[2]) begin
      calc_res = (funct3_q[1:0] == 2'b00) ? signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN];
    end else if (funct3_q[1]) begin
      calc_res = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    end else begin
      calc_res = signed_prod[XLEN-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          funct3_d = funct3;
          neg_d    = (is_div && funct3[1]) ? neg1 : (neg1 ^ neg2);
          cnt_d    = '0;
          opnd_d   = is_div ? mag2 : mag1;
          prod_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = fast_res;
            state_d  = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        prod_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          result_d = calc_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A flushed operation never completes, so result keeps the last completed value
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with XLEN = 32.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 0;
`else
  localparam int MulLat = 32;
`endif
  localparam int DivLat = 32;
  localparam int SpcLat = 0;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;

  int checks = 0;
  int fails  = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3   = f;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid shows; 100 means it never came
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f, a, b);
    wait_valid(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    tick();
    check({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;

    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'h0);
    reset_n = 1'b1;
    tick();

    run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
    run_op("MULH 7*-3",       3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, MulLat);
    run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DivLat);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DivLat);
    run_op("DIVU 7/2",        3'b101, 32'd7,          32'd2,         32'd3,         DivLat);
    run_op("REMU 7/2",        3'b111, 32'd7,          32'd2,         32'd1,         DivLat);
    run_op("DIV 5/0",         3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, SpcLat);
    run_op("REM 5/0",         3'b110, 32'd5,          32'd0,         32'd5,         SpcLat);
    run_op("REMU 9/0",        3'b111, 32'd9,          32'd0,         32'd9,         SpcLat);
    run_op("DIV ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SpcLat);
    run_op("REM ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         SpcLat);

    // Backpressure: result must sit still while out_ready is low
    out_ready = 1'b0;
    issue(3'b101, 32'd7, 32'd2);
    wait_valid(lat);
    check("bp latency", lat, DivLat);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp result stable", result, 32'd3);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);

    // Flush in the 10th cycle of a divide
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush no late out_valid", seen, 32'd0);
    check("flush result kept", result, 32'd3);
    run_op("DIVU 100/7 after flush", 3'b101, 32'd100, 32'd7, 32'd14, DivLat);

    // Flush together with a request in IDLE must not accept it
    funct3   = 3'b100;
    op1      = 32'd5;
    op2      = 32'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush+req not accepted", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    issue(3'b000, 32'd7, 32'd3);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("midreset result", result, 32'h0);
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("DIVU 100/7 after reset", 3'b101, 32'd100, 32'd7, 32'd14, DivLat);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
